// File: rtl/npc_pkg.sv
// Shared NPC core constants: default datapath geometry and the hardwired-zero register index.
// No logic, no latency, no flow control.
// Imported by the register file and its scoreboard.
package npc_pkg;
    localparam int          XLEN_DEFAULT = 32;
    localparam int          NREG_DEFAULT = 32;
    localparam int unsigned REG_ZERO     = 0;
endpackage

// File: rtl/gpr_sb_core.sv
// Busy scoreboard: one bit per register, set by issue-stage reserve, cleared by writeback.
// State updates on the clock edge; busy_vec is registered state only.
// No backpressure: every reserve and write is accepted on the edge it is presented.
module gpr_sb_core
    import npc_pkg::*;
#(
    parameter  int NREG     = NREG_DEFAULT,
    parameter  int NWR      = 1,
    parameter  bit ZERO_REG = 1'b1,
    localparam int AW       = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_addr,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    output logic [NREG-1:0]   busy_vec
);

    logic [NREG-1:0] busy_nxt;

    // Clears are applied first so a same-cycle reserve (new producer) wins.
    always_comb begin
        busy_nxt = busy_vec;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j]) busy_nxt[wr_addr[j*AW +: AW]] = 1'b0;
        end
        if (rsv_en && !(ZERO_REG && rsv_addr == AW'(REG_ZERO))) busy_nxt[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_vec <= '0;
        else     busy_vec <= busy_nxt;
    end

endmodule

// File: rtl/gpr_file_sb.sv
// Multi-port GPR file with optional write-to-read bypass and integrated busy scoreboard.
// Reads are combinational (zero latency); writes land on the clock edge.
// No backpressure: all read, write and reserve requests are serviced every cycle.
module gpr_file_sb
    import npc_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEFAULT,
    parameter  int NREG     = NREG_DEFAULT,
    parameter  int NRD      = 2,
    parameter  int NWR      = 1,
    parameter  bit ZERO_REG = 1'b1,
    parameter  bit BYPASS   = 1'b1,
    localparam int AW       = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic [NREG-1:0]     busy_vec
);

    logic [XLEN-1:0] regs [NREG];

    // Ports are applied in ascending order so the highest index wins a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) regs[r] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && !(ZERO_REG && wr_addr[j*AW +: AW] == AW'(REG_ZERO)))
                    regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
            end
        end
    end

    gpr_sb_core #(
        .NREG     (NREG),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .busy_vec (busy_vec)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] fwd_data;
        logic [XLEN-1:0] data;
        logic            hit;
        logic            busy;
        logic            is_zero;
        logic            rsv_hit;

        assign ra      = rd_addr[i*AW +: AW];
        assign is_zero = ZERO_REG && (ra == AW'(REG_ZERO));
        assign rsv_hit = rsv_en && (rsv_addr == ra);

        always_comb begin
            hit      = 1'b0;
            fwd_data = '0;
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && wr_addr[j*AW +: AW] == ra) begin
                    hit      = 1'b1;
                    fwd_data = wr_data[j*XLEN +: XLEN];
                end
            end
        end

        // Writes presented during reset are discarded, so they must not be forwarded either.
        always_comb begin
            data = regs[ra];
            busy = busy_vec[ra];
            if (BYPASS && hit && !rst) begin
                data = fwd_data;
                if (!rsv_hit) busy = 1'b0;
            end
            if (is_zero) begin
                data = '0;
                busy = 1'b0;
            end
        end

        assign rd_data[i*XLEN +: XLEN] = data;
        assign rd_busy[i]              = busy;
    end

endmodule

// File: doc/gpr_file_sb.md
Name: gpr_file_sb

Overview:
- Parametrised general-purpose register file for the NPC core; the next generation of the single-write, two-read GPR.
- Configurable data width, register count, read-port count and write-port count.
- Optional write-to-read bypass.
- Integrated busy scoreboard: the issue stage reserves a destination, and writeback clears it, so the hazard logic can stall on pending producers.

Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of architectural registers (power of two, ≥2).
- NRD, 2, number of read ports.
- NWR, 1, number of write ports (1..4).
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes and reservations.
- BYPASS, 1, when 1 same-cycle write data is forwarded to matching reads.
- AW, $clog2(NREG), derived address width; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- rd_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data, combinational.
- rd_busy  out  NRD  1 = addressed register has an outstanding reservation.
- wr_en  in  NWR  per-port write enable.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- rsv_en  in  1  reserve a destination register (issue stage).
- rsv_addr  in  AW  register to reserve.
- busy_vec  out  NREG  full scoreboard, bit r = register r busy.

Behaviour:
- Reset is synchronous. At a rising clk with rst=1, all registers become 0 and all busy bits become 0. Write and reserve inputs on that edge are ignored.
- With rst=1 held, rd_data reads 0 from the cycle after the first reset edge, and rd_busy/busy_vec read 0.
- Before the first reset edge, contents are undefined.

Writes:
- On a rising edge with wr_en[j]=1, register wr_addr[j] takes wr_data[j].
- If ZERO_REG=1 and wr_addr[j]=0, the write is dropped.
- Two ports writing the same address in the same cycle: the highest port index wins, for storage and for bypass alike.

Reads:
- Combinational, zero latency.
- If ZERO_REG=1 and rd_addr[i]=0, rd_data[i]=0 and rd_busy[i]=0 regardless of state.
- If BYPASS=1 and any wr_en[j] matches rd_addr[i] (non-zero or ZERO_REG=0), rd_data[i] is the winning wr_data[j]. Otherwise rd_data[i] is the stored value.
- If BYPASS=0, reads return the stored value; the new value is visible the cycle after the write edge.

Scoreboard:
- Rising edge with rsv_en=1: busy[rsv_addr] is set; ignored for register 0 when ZERO_REG=1.
- Rising edge with wr_en[j]=1: busy[wr_addr[j]] is cleared.
- Reserve and write to the same register in the same cycle: set wins, because the new producer supersedes the completing one. The data write still occurs.
- Reserving an already-busy register keeps it busy; there is no counting, single outstanding producer per register.
- Writing a non-busy register is legal and leaves it not busy.
- rd_busy[i] = busy_vec[rd_addr[i]] from the current register state. When BYPASS=1, rd_busy[i] is also 0 if a same-cycle write matches and no same-cycle reserve hits that address. This gives write-clears-busy bypass consistent with the data bypass.
- busy_vec reflects registered state only (no bypass).

Width rules: addresses are unsigned AW bits, so no out-of-range access is possible. All data paths are exactly XLEN bits.

Reset mid-operation: any pending reservations are discarded, and the writes presented in the reset cycle are lost.

Decomposition:
- Shared package npc_pkg holds XLEN_DEFAULT=32, NREG_DEFAULT=32, and the REG_ZERO=0 constant.
- One sub-module, gpr_sb_core: the NREG-bit busy scoreboard (set/clear, priority, reset). The storage array and read/bypass muxing stay in gpr_file_sb.

Test Plan:
- Reset with rst=1 for 2 cycles after random writes; read all 32 regs → all 0, busy_vec=0.
- Write x5=0xDEADBEEF with BYPASS=1, rd_addr[0]=5 in the same cycle → rd_data[0]=0xDEADBEEF immediately. With BYPASS=0 → old value, then 0xDEADBEEF next cycle.
- Write x0=0x12345678 and rsv x0 (ZERO_REG=1) → rd_data=0, rd_busy=0, busy_vec[0]=0.
- NWR=2, both ports write x7 with 0x1 (port0) and 0x2 (port1) → x7 reads 0x2.
- rsv x3 → busy_vec[3]=1 next cycle; later wr x3=0x55 with rsv x3 in the same cycle → busy_vec[3] stays 1 and x3=0x55. Then wr x3=0x66 alone → busy_vec[3]=0, and during that write cycle rd_busy for x3 is 0 (BYPASS=1).
- rsv x9 then assert rst while busy → busy_vec=0 and x9=0 after the edge.
